// File: rtl/ct_hpcp_pkg.sv
// Shared constants for the HPCP counter-overflow status bank:
// interrupt FSM state encoding, clear-mode selectors and channel limits.
package ct_hpcp_pkg;

  localparam int CNTOF_NUM_CNT_MAX = 64;

  localparam int CNTOF_CLR_DIRECT = 0;
  localparam int CNTOF_CLR_W1C    = 1;

  typedef enum logic [1:0] {
    CNTOF_IDLE = 2'b00,
    CNTOF_REQ  = 2'b01,
    CNTOF_WAIT = 2'b10
  } cntof_irq_state_e;

endpackage

// File: rtl/ct_hpcp_cntof_bit.sv
// One sticky overflow status bit.
// CLR_MODE selects direct write or write-1-to-clear. In both modes an
// overflow pulse in the same cycle as a write always wins.
module ct_hpcp_cntof_bit
  import ct_hpcp_pkg::*;
#(
  parameter int CLR_MODE = CNTOF_CLR_DIRECT
) (
  input  logic hpcp_clk,
  input  logic cpurst,
  input  logic wr_en,
  input  logic wdata,
  input  logic overflow,
  output logic cntof
);

  logic cntof_nxt;

  // Next-state value of the sticky bit.
  always_comb begin
    cntof_nxt = cntof | overflow;
    if (wr_en) begin
      if (CLR_MODE == CNTOF_CLR_W1C)
        cntof_nxt = (cntof & ~wdata) | overflow;
      else
        cntof_nxt = wdata | overflow;
    end
  end

  // Status register; reset overrides any write or overflow.
  always_ff @(posedge hpcp_clk) begin
    if (cpurst)
      cntof <= 1'b0;
    else
      cntof <= cntof_nxt;
  end

endmodule

// File: rtl/ct_hpcp_cntof_bank.sv
// HPCP counter-overflow status bank with optional interrupt handshake.
// Optional feature macro: CT_HPCP_CNTOF_IRQ_EN builds the request/ack FSM;
// without it cntof_irq_req is tied low and irq_ack is ignored.
//
// state      | meaning
// -----------+-------------------------------------------------------
// CNTOF_IDLE | no request outstanding, waiting for an enabled bit
// CNTOF_REQ  | cntof_irq_req asserted, waiting for irq_ack
// CNTOF_WAIT | acknowledged; hold off until all enabled bits clear
module ct_hpcp_cntof_bank
  import ct_hpcp_pkg::*;
#(
  parameter int NUM_CNT  = 32,
  parameter int CLR_MODE = CNTOF_CLR_DIRECT
) (
  input  logic               hpcp_clk,
  input  logic               cpurst,
  input  logic               cntof_wen,
  input  logic               l2cnt_cmplt_ff,
  input  logic [NUM_CNT-1:0] hpcp_wdata,
  input  logic [NUM_CNT-1:0] counter_overflow,
  input  logic [NUM_CNT-1:0] cntof_inten,
  input  logic               irq_ack,
  output logic [NUM_CNT-1:0] cntof,
  output logic               cntof_any,
  output logic               cntof_irq_req
);

  logic wr_en;

  // A write lands only when the strobe is qualified.
  assign wr_en = cntof_wen & l2cnt_cmplt_ff;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_bit
      ct_hpcp_cntof_bit #(
        .CLR_MODE (CLR_MODE)
      ) u_bit (
        .hpcp_clk (hpcp_clk),
        .cpurst   (cpurst),
        .wr_en    (wr_en),
        .wdata    (hpcp_wdata[gi]),
        .overflow (counter_overflow[gi]),
        .cntof    (cntof[gi])
      );
    end
  endgenerate

  // Pending is live: an inten change is seen the same cycle.
  assign cntof_any = |(cntof & cntof_inten);

`ifdef CT_HPCP_CNTOF_IRQ_EN

  cntof_irq_state_e state;
  cntof_irq_state_e state_nxt;

  // State register.
  always_ff @(posedge hpcp_clk) begin
    if (cpurst)
      state <= CNTOF_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode; irq_ack matters only while a request is up.
  always_comb begin
    state_nxt = state;
    case (state)
      CNTOF_IDLE: if (cntof_any) state_nxt = CNTOF_REQ;
      CNTOF_REQ: begin
        if (!cntof_any)   state_nxt = CNTOF_IDLE;
        else if (irq_ack) state_nxt = CNTOF_WAIT;
      end
      CNTOF_WAIT: if (!cntof_any) state_nxt = CNTOF_IDLE;
      default:    state_nxt = CNTOF_IDLE;
    endcase
  end

  // Request is a pure decode of the state register, so it is glitch-free.
  always_comb begin
    cntof_irq_req = (state == CNTOF_REQ);
  end

`else

  logic irq_ack_unused;

  assign irq_ack_unused = irq_ack;
  assign cntof_irq_req  = 1'b0;

`endif

endmodule

// File: tb/tb_ct_hpcp_cntof_bank.sv
// Directed bench for ct_hpcp_cntof_bank: one direct-write bank and one
// write-1-to-clear bank, both with 8 channels.
module tb_ct_hpcp_cntof_bank;

`ifdef CT_HPCP_CNTOF_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic       hpcp_clk = 1'b0;
  logic       cpurst   = 1'b1;

  logic       wen0 = 0, l20 = 0, ack0 = 0;
  logic [7:0] wd0 = 0, ovf0 = 0, ien0 = 8'hFF;
  logic [7:0] cntof0;
  logic       any0, irq0;

  logic       wen1 = 0, l21 = 0, ack1 = 0;
  logic [7:0] wd1 = 0, ovf1 = 0, ien1 = 8'hFF;
  logic [7:0] cntof1;
  logic       any1, irq1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 hpcp_clk = ~hpcp_clk;

  ct_hpcp_cntof_bank #(.NUM_CNT(8), .CLR_MODE(0)) u_dut0 (
    .hpcp_clk         (hpcp_clk),
    .cpurst           (cpurst),
    .cntof_wen        (wen0),
    .l2cnt_cmplt_ff   (l20),
    .hpcp_wdata       (wd0),
    .counter_overflow (ovf0),
    .cntof_inten      (ien0),
    .irq_ack          (ack0),
    .cntof            (cntof0),
    .cntof_any        (any0),
    .cntof_irq_req    (irq0)
  );

  ct_hpcp_cntof_bank #(.NUM_CNT(8), .CLR_MODE(1)) u_dut1 (
    .hpcp_clk         (hpcp_clk),
    .cpurst           (cpurst),
    .cntof_wen        (wen1),
    .l2cnt_cmplt_ff   (l21),
    .hpcp_wdata       (wd1),
    .counter_overflow (ovf1),
    .cntof_inten      (ien1),
    .irq_ack          (ack1),
    .cntof            (cntof1),
    .cntof_any        (any1),
    .cntof_irq_req    (irq1)
  );

  task automatic step();
    @(posedge hpcp_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset while a write and overflows are present
    cpurst = 1; wen0 = 1; l20 = 1; wd0 = 8'hFF; ovf0 = 8'hFF;
    ovf1 = 8'hFF;
    step(); step();
    chk("rst_cntof0", cntof0, 8'h00);
    chk("rst_irq0",   {7'd0, irq0}, 8'h00);
    chk("rst_cntof1", cntof1, 8'h00);
    cpurst = 0; wen0 = 0; l20 = 0; wd0 = 0; ovf0 = 0; ovf1 = 0;
    step();
    chk("idle_cntof0", cntof0, 8'h00);

    // overflow on ch3: status at t+1, request at t+2
    ovf0 = 8'h08;
    step();
    ovf0 = 0;
    chk("ovf3_cntof", cntof0, 8'h08);
    chk("ovf3_any",   {7'd0, any0}, 8'h01);
    chk("ovf3_irq_t1", {7'd0, irq0}, 8'h00);
    step();
    chk("ovf3_irq_t2", {7'd0, irq0}, {7'd0, IRQ});

    // acknowledge: request drops next cycle
    ack0 = 1;
    step();
    ack0 = 0;
    chk("ack_irq_drop", {7'd0, irq0}, 8'h00);

    // new overflow while waiting: no new request
    ovf0 = 8'h02;
    step();
    ovf0 = 0;
    chk("wait_ovf_cntof", cntof0, 8'h0A);
    step();
    chk("wait_ovf_irq", {7'd0, irq0}, 8'h00);

    // direct write of zero with simultaneous overflow on ch5
    wen0 = 1; l20 = 1; wd0 = 8'h00; ovf0 = 8'h20;
    step();
    ovf0 = 0;
    chk("wr_ovf5_cntof", cntof0, 8'h20);
    chk("wr_ovf5_irq", {7'd0, irq0}, 8'h00);

    // clear all enabled bits -> FSM back to IDLE
    step();
    wen0 = 0; l20 = 0;
    chk("clr_cntof", cntof0, 8'h00);
    chk("clr_any", {7'd0, any0}, 8'h00);
    ack0 = 1;
    step();
    ack0 = 0;
    chk("idle_ack_irq", {7'd0, irq0}, 8'h00);

    // unqualified write ignored, overflow still lands
    wen0 = 1; l20 = 0; wd0 = 8'h00; ovf0 = 8'h20;
    step();
    ovf0 = 0; wd0 = 8'hFF;
    step();
    wen0 = 0; wd0 = 0;
    chk("unq_wr_cntof", cntof0, 8'h20);
    chk("new_req_irq", {7'd0, irq0}, {7'd0, IRQ});

    // software clears before ack: request withdrawn
    wen0 = 1; l20 = 1; wd0 = 8'h00;
    step();
    wen0 = 0; l20 = 0;
    chk("sw_clr_cntof", cntof0, 8'h00);
    chk("sw_clr_irq_hold", {7'd0, irq0}, {7'd0, IRQ});
    step();
    chk("sw_clr_irq_drop", {7'd0, irq0}, 8'h00);

    // disabled channel: no request until enabled
    ien0 = 8'h00; ovf0 = 8'h10;
    step();
    ovf0 = 0;
    chk("dis_cntof", cntof0, 8'h10);
    chk("dis_any", {7'd0, any0}, 8'h00);
    step(); step();
    chk("dis_irq", {7'd0, irq0}, 8'h00);
    ien0 = 8'h10;
    #1;
    chk("en_any_same", {7'd0, any0}, 8'h01);
    step();
    chk("en_irq", {7'd0, irq0}, {7'd0, IRQ});

    // reset in REQ abandons the handshake
    cpurst = 1;
    step();
    cpurst = 0;
    chk("rst_req_cntof", cntof0, 8'h00);
    chk("rst_req_irq", {7'd0, irq0}, 8'h00);
    step(); step();
    chk("post_rst_irq", {7'd0, irq0}, 8'h00);

    // write-1-to-clear bank
    ovf1 = 8'h0F;
    step();
    ovf1 = 0;
    chk("w1c_set", cntof1, 8'h0F);
    wen1 = 1; l21 = 1; wd1 = 8'h05; ovf1 = 8'h01;
    step();
    ovf1 = 0; l21 = 0; wd1 = 8'hFF;
    chk("w1c_clr_ovf", cntof1, 8'h0B);
    step();
    chk("w1c_unq", cntof1, 8'h0B);
    l21 = 1; wd1 = 8'h00;
    step();
    chk("w1c_zero", cntof1, 8'h0B);
    wd1 = 8'h0A;
    step();
    wen1 = 0; l21 = 0; wd1 = 0;
    chk("w1c_part", cntof1, 8'h01);
    chk("w1c_any", {7'd0, any1}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ct_hpcp_cntof_bank.md
CT_HPCP_CNTOF_BANK -- requirements
Module: ct_hpcp_cntof_bank

Interface
REQ-001 SHALL have parameter NUM_CNT, default 32, giving the number of counter channels (1..64).
REQ-002 SHALL have parameter CLR_MODE, default 0: 0 = direct write, 1 = write-1-to-clear.
REQ-003 SHALL have port hpcp_clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port cpurst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port cntof_wen, input, 1, status-register write strobe.
REQ-006 SHALL have port l2cnt_cmplt_ff, input, 1, write-qualify flag; a write takes effect only when this and cntof_wen are both 1.
REQ-007 SHALL have port hpcp_wdata, input, NUM_CNT, write data, bit i for channel i.
REQ-008 SHALL have port counter_overflow, input, NUM_CNT, one-cycle overflow pulse per channel.
REQ-009 SHALL have port cntof_inten, input, NUM_CNT, per-channel interrupt enable.
REQ-010 SHALL have port irq_ack, input, 1, interrupt acknowledge from the interrupt controller.
REQ-011 SHALL have port cntof, output, NUM_CNT, registered sticky overflow status.
REQ-012 SHALL have port cntof_any, output, 1, combinational OR of (cntof AND cntof_inten).
REQ-013 SHALL have port cntof_irq_req, output, 1, registered interrupt request.

Function
REQ-014 Per channel, with no qualified write: cntof[i] next = cntof[i] OR counter_overflow[i]; overflow pulse at cycle t is visible at t+1.
REQ-015 CLR_MODE=0 qualified write: cntof[i] next = hpcp_wdata[i] OR counter_overflow[i]; an overflow is never lost to a simultaneous write.
REQ-016 CLR_MODE=1 qualified write: cntof[i] next = (cntof[i] AND NOT hpcp_wdata[i]) OR counter_overflow[i]; a set in the same cycle dominates a clear.
REQ-017 cntof_wen with l2cnt_cmplt_ff=0 SHALL leave every bit governed by REQ-014 only.
REQ-018 Interrupt FSM states: IDLE, REQ, WAIT; pending = cntof_any.
REQ-019 IDLE -> REQ when pending=1; cntof_irq_req=1 exactly while in REQ, so it rises one cycle after the status bit (t+2 from the overflow pulse).
REQ-020 REQ -> WAIT on irq_ack=1; cntof_irq_req drops the following cycle.
REQ-021 WAIT -> IDLE when pending=0; no new request is raised while any enabled bit stays set.
REQ-022 REQ -> IDLE if pending falls to 0 before irq_ack (software cleared it first); request is withdrawn.
REQ-023 irq_ack in IDLE or WAIT SHALL be ignored.
REQ-024 A change of cntof_inten SHALL take effect on pending in the same cycle; enabling a channel that already has its bit set SHALL raise a request per REQ-019.

Reset
REQ-025 cpurst=1 at a clock edge SHALL set cntof to all zeros, the FSM to IDLE, and cntof_irq_req to 0, overriding any simultaneous write or overflow.
REQ-026 Reset asserted in REQ or WAIT SHALL abandon the handshake; no request follows reset release unless a new overflow occurs.

Configuration
REQ-027 Macro CT_HPCP_CNTOF_IRQ_EN: when defined, the FSM and REQ-018..REQ-024 are present.
REQ-028 Without CT_HPCP_CNTOF_IRQ_EN: no FSM state is built, cntof_irq_req is tied 0, and irq_ack is unused; cntof and cntof_any behave identically.

Structure
REQ-029 A shared package ct_hpcp_pkg SHALL hold the FSM state encoding (IDLE=2'b00, REQ=2'b01, WAIT=2'b10), the CLR_MODE constants, and the NUM_CNT upper bound.
REQ-030 Per-channel bit logic SHALL be one sub-module, ct_hpcp_cntof_bit, instantiated NUM_CNT times through a generate loop; the FSM lives in the top module.

Verification
REQ-031 CLR_MODE=0, NUM_CNT=8: overflow pulse on ch3 at t -> cntof=8'h08 at t+1, cntof_irq_req=1 at t+2 with inten=8'hFF.
REQ-032 CLR_MODE=0: write hpcp_wdata=8'h00 with l2cnt_cmplt_ff=1 in the same cycle as an overflow on ch5 -> cntof=8'h20; repeat with l2cnt_cmplt_ff=0 -> write ignored.
REQ-033 CLR_MODE=1: cntof=8'h0F, W1C write 8'h05 plus overflow on ch0 in the same cycle -> cntof=8'h0B.
REQ-034 Handshake: REQ state, irq_ack pulse -> irq_req=0 next cycle; a new overflow while in WAIT -> no request; clear all enabled bits -> IDLE; next overflow -> new request.
REQ-035 inten=0 with cntof=8'h10 -> no request; set inten[4]=1 -> irq_req=1 next cycle; assert cpurst while in REQ -> cntof=0 and irq_req=0 the next cycle.
REQ-036 Build without CT_HPCP_CNTOF_IRQ_EN: rerun REQ-031 -> cntof matches and cntof_irq_req stays 0.
